// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: opcodes, FSM states and counter sizing.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_DIVU  = 2'b01,
        OP_MULT  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        FIXUP = 2'b10
    } state_e;

    // Iteration counter must hold the value WIDTH itself.
    localparam int CNT_W = $clog2(32 + 1);

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between the EX-stage hazard/control logic and the multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = 32);

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wd;
    logic             busy;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, flush, hi_we, lo_we, wd,
        input  busy, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, flush, hi_we, lo_we, wd,
        output busy, div_by_zero, hi, lo
    );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step (quotient lives in acc low half).
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH:0]     rem_in,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] acc_out,
    output logic [WIDTH:0]     rem_out
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, mcand} : '0);
        shifted = {rem_in[WIDTH-1:0], acc_in[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        acc_out = {sum, acc_in[WIDTH-1:1]};
        rem_out = rem_in;
        if (is_div) begin
            // A set MSB on the trial means the divisor did not fit: restore.
            rem_out = trial[WIDTH] ? shifted : trial;
            acc_out = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-2:0], ~trial[WIDTH]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULTU/DIVU unit with HI/LO registers; define MULDIV_SIGNED_EN to add MULT/DIV via a FIXUP cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     reset,
    muldiv_if.slave bus
);

    localparam int         CW       = $clog2(WIDTH + 1);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_FIXUP = FIXUP;

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH:0]     rem, rem_nxt;
    logic [WIDTH-1:0]   mcand, divisor, hi_q, lo_q;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               is_div, dbz_q;
    logic               issue, dbz_hit, last_iter, op_signed;

`ifdef MULDIV_SIGNED_EN
    logic               is_signed, neg_res, neg_rem;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_hi, fix_lo;
`endif

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .acc_in  (acc),
        .rem_in  (rem),
        .mcand   (mcand),
        .divisor (divisor),
        .acc_out (acc_nxt),
        .rem_out (rem_nxt)
    );

    always_comb begin
`ifdef MULDIV_SIGNED_EN
        op_signed = bus.op[1];
        prod      = neg_res ? -acc : acc;
        fix_hi    = is_div ? (neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0]) : prod[2*WIDTH-1:WIDTH];
        fix_lo    = is_div ? (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]) : prod[WIDTH-1:0];
`else
        op_signed = 1'b0;
`endif
        a_mag     = magnitude(bus.src_a, op_signed);
        b_mag     = magnitude(bus.src_b, op_signed);
        // Flush in the issue cycle swallows the start.
        issue     = (state == ST_IDLE) && bus.start && !bus.flush;
        dbz_hit   = issue && bus.op[0] && (bus.src_b == '0);
        last_iter = (state == ST_RUN) && (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            count   <= '0;
            acc     <= '0;
            rem     <= '0;
            mcand   <= '0;
            divisor <= '0;
            is_div  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULDIV_SIGNED_EN
            is_signed <= 1'b0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
`endif
        end else begin
            dbz_q <= dbz_hit;
            case (state)
                ST_IDLE: begin
                    if (issue && !dbz_hit) begin
                        state   <= ST_RUN;
                        count   <= '0;
                        is_div  <= bus.op[0];
                        mcand   <= a_mag;
                        divisor <= b_mag;
                        acc     <= {{WIDTH{1'b0}}, bus.op[0] ? a_mag : b_mag};
                        rem     <= '0;
`ifdef MULDIV_SIGNED_EN
                        is_signed <= op_signed;
                        neg_res   <= op_signed & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
                        neg_rem   <= op_signed & bus.src_a[WIDTH-1];
`endif
                    end else if (!bus.start) begin
                        if (bus.hi_we) hi_q <= bus.wd;
                        if (bus.lo_we) lo_q <= bus.wd;
                    end
                end
                ST_RUN: begin
                    if (bus.flush) begin
                        state <= ST_IDLE;
                    end else begin
                        acc   <= acc_nxt;
                        rem   <= rem_nxt;
                        count <= count + CW'(1);
                        if (last_iter) begin
                            state <= ST_IDLE;
                            hi_q  <= is_div ? rem_nxt[WIDTH-1:0] : acc_nxt[2*WIDTH-1:WIDTH];
                            lo_q  <= acc_nxt[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
                            // Signed ops hold the magnitudes one more cycle for sign correction.
                            if (is_signed) begin
                                state <= ST_FIXUP;
                                hi_q  <= hi_q;
                                lo_q  <= lo_q;
                            end
`endif
                        end
                    end
                end
                ST_FIXUP: begin
`ifdef MULDIV_SIGNED_EN
                    if (!bus.flush) begin
                        hi_q <= fix_hi;
                        lo_q <= fix_lo;
                    end
`endif
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy        = (state != ST_IDLE);
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus randomized ops against an arithmetic model.
module tb_muldiv_unit;

`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [31:0] exp_hi, exp_lo;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operands.
    task automatic ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] rh, output logic [31:0] rl, output int lat);
        logic   sgn;
        longint sa, sb, sq, sr;
        logic [63:0] p;
        sgn = SIGNED_BUILD && op[1];
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        if (!op[0]) begin
            if (sgn) p = 64'(sa * sb);
            else     p = {32'b0, a} * {32'b0, b};
            rh = p[63:32];
            rl = p[31:0];
        end else if (sgn) begin
            sq = sa / sb;
            sr = sa % sb;
            rl = sq[31:0];
            rh = sr[31:0];
        end else begin
            rl = a / b;
            rh = a % b;
        end
        lat = sgn ? 33 : 32;
    endtask

    // Issues one op and counts the cycles busy stays high (bounded).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles, output logic dbz);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        dbz = bus.div_by_zero;
        cycles = 0;
        while (bus.busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic write_hilo(input logic [31:0] v);
        @(negedge clk);
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wd = v;
        @(negedge clk);
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bus.busy, bus.div_by_zero, bus.hi, bus.lo} !== 66'b0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b dbz=%b hi=%h lo=%h, required all zero",
                     bus.busy, bus.div_by_zero, bus.hi, bus.lo);
        end
        reset = 1'b1;
    endtask

    task automatic test_multu_max();
        int c; logic d;
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c, d);
        n_tests++;
        if (c !== 32) begin n_fail++; $display("FAIL multu_max_busy: got %0d required 32", c); end
        n_tests++;
        if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL multu_max_result: got %h_%h required fffffffe_00000001", bus.hi, bus.lo);
        end
    endtask

    task automatic test_divu();
        int c; logic d;
        run_op(2'b01, 32'd100, 32'd7, c, d);
        n_tests++;
        if (c !== 32) begin n_fail++; $display("FAIL divu_busy: got %0d required 32", c); end
        n_tests++;
        if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
            n_fail++;
            $display("FAIL divu_result: got q=%0d r=%0d required q=14 r=2", bus.lo, bus.hi);
        end
    endtask

    task automatic test_div_by_zero();
        int c; logic d;
        write_hilo(32'h1234);
        run_op(2'b01, 32'd5, 32'd0, c, d);
        n_tests++;
        if (d !== 1'b1 || c !== 0) begin
            n_fail++;
            $display("FAIL dbz_pulse: got dbz=%b busy_cycles=%0d required dbz=1 busy_cycles=0", d, c);
        end
        @(negedge clk);
        n_tests++;
        if (bus.div_by_zero !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL dbz_single: got dbz=%b busy=%b required 0 0", bus.div_by_zero, bus.busy);
        end
        n_tests++;
        if (bus.hi !== 32'h1234 || bus.lo !== 32'h1234) begin
            n_fail++;
            $display("FAIL dbz_hilo: got hi=%h lo=%h required 00001234", bus.hi, bus.lo);
        end
    endtask

    task automatic test_flush();
        int n; logic was_busy;
        write_hilo(32'h0BAD_F00D);
        // Flush on the 10th busy cycle and on the completing cycle.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'd3; bus.src_b = 32'd4;
            @(negedge clk);
            bus.start = 1'b0;
            n = 1;
            while (n < (k == 0 ? 10 : 32) && bus.busy) begin @(negedge clk); n++; end
            was_busy = bus.busy;
            bus.flush = 1'b1;
            @(negedge clk);
            bus.flush = 1'b0;
            n_tests++;
            if (was_busy !== 1'b1 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_busy_%0d: busy before=%b after=%b required 1 0", k, was_busy, bus.busy);
            end
            n_tests++;
            if (bus.hi !== 32'h0BAD_F00D || bus.lo !== 32'h0BAD_F00D) begin
                n_fail++;
                $display("FAIL flush_hilo_%0d: got hi=%h lo=%h required 0badf00d", k, bus.hi, bus.lo);
            end
        end
        // Flush while idle must not disturb anything.
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL flush_idle: got busy=%b hi=%h required 0 0badf00d", bus.busy, bus.hi);
        end
        // Start on the completing cycle is ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'd3; bus.src_b = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (n < 32 && bus.busy) begin @(negedge clk); n++; end
        bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'd9; bus.src_b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd12) begin
            n_fail++;
            $display("FAIL start_at_completion: got busy=%b hi=%h lo=%h required 0 0 c", bus.busy, bus.hi, bus.lo);
        end
    endtask

    task automatic test_reset_mid_op_and_mt();
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'd7; bus.src_b = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (n < 5 && bus.busy) begin @(negedge clk); n++; end
        reset = 1'b0;
        #1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_op: got busy=%b hi=%h lo=%h required 0 0 0", bus.busy, bus.hi, bus.lo);
        end
        @(negedge clk);
        reset = 1'b1;
        bus.hi_we = 1'b1; bus.wd = 32'hA5A5_A5A5;
        @(negedge clk);
        bus.hi_we = 1'b0;
        n_tests++;
        if (bus.hi !== 32'hA5A5_A5A5 || bus.lo !== 32'd0) begin
            n_fail++;
            $display("FAIL mthi_idle: got hi=%h lo=%h required a5a5a5a5 0", bus.hi, bus.lo);
        end
        bus.lo_we = 1'b1; bus.wd = 32'h5A5A_0001;
        @(negedge clk);
        bus.lo_we = 1'b0;
        n_tests++;
        if (bus.lo !== 32'h5A5A_0001 || bus.hi !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL mtlo_idle: got hi=%h lo=%h required a5a5a5a5 5a5a0001", bus.hi, bus.lo);
        end
        // Write alongside start, then held through busy: both dropped.
        bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'd3; bus.src_b = 32'd4;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wd = 32'hFFFF_0000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b1 || bus.hi !== 32'hA5A5_A5A5 || bus.lo !== 32'h5A5A_0001) begin
            n_fail++;
            $display("FAIL mt_while_busy: got busy=%b hi=%h lo=%h required 1 a5a5a5a5 5a5a0001",
                     bus.busy, bus.hi, bus.lo);
        end
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        n = 0;
        while (bus.busy && n < 100) begin @(negedge clk); n++; end
        n_tests++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd12) begin
            n_fail++;
            $display("FAIL mt_then_result: got hi=%h lo=%h required 0 c", bus.hi, bus.lo);
        end
    endtask

    task automatic test_signed_ops();
        int c; logic d;
        logic [31:0] rh, rl; int lat;
        run_op(2'b10, 32'hFFFF_FFFD, 32'd5, c, d);
        ref_model(2'b10, 32'hFFFF_FFFD, 32'd5, rh, rl, lat);
`ifdef MULDIV_SIGNED_EN
        n_tests++;
        if (c !== 33 || bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFF1) begin
            n_fail++;
            $display("FAIL mult_neg3x5: got busy=%0d %h_%h required 33 ffffffff_fffffff1", c, bus.hi, bus.lo);
        end
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, c, d);
        n_tests++;
        if (c !== 33 || bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL div_neg7by2: got busy=%0d q=%h r=%h required 33 fffffffd ffffffff", c, bus.lo, bus.hi);
        end
`else
        n_tests++;
        if (c !== lat || bus.hi !== rh || bus.lo !== rl) begin
            n_fail++;
            $display("FAIL mult_as_unsigned: got busy=%0d %h_%h required %0d %h_%h", c, bus.hi, bus.lo, lat, rh, rl);
        end
`endif
    endtask

    task automatic test_random();
        int c, lat; logic d;
        logic [1:0]  op;
        logic [31:0] a, b, rh, rl;
        exp_hi = bus.hi;
        exp_lo = bus.lo;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom();
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom();
            run_op(op, a, b, c, d);
            n_tests++;
            if (op[0] && b == 32'd0) begin
                if (d !== 1'b1 || c !== 0 || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
                    n_fail++;
                    $display("FAIL rand_dbz[%0d]: got dbz=%b busy=%0d hi=%h lo=%h required 1 0 %h %h",
                             i, d, c, bus.hi, bus.lo, exp_hi, exp_lo);
                end
            end else begin
                ref_model(op, a, b, rh, rl, lat);
                exp_hi = rh;
                exp_lo = rl;
                if (d !== 1'b0 || c !== lat || bus.hi !== rh || bus.lo !== rl) begin
                    n_fail++;
                    $display("FAIL rand_op[%0d] op=%0d a=%h b=%h: got dbz=%b busy=%0d %h_%h required 0 %0d %h_%h",
                             i, op, a, b, d, c, bus.hi, bus.lo, lat, rh, rl);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int c, lat; logic d;
        logic [31:0] rh, rl;
        for (int i = 0; i < 4; i++) begin
            run_op(2'(i), 32'h8000_0000 + 32'(i), 32'hFFFF_FFFF - 32'(i), c, d);
            ref_model(2'(i), 32'h8000_0000 + 32'(i), 32'hFFFF_FFFF - 32'(i), rh, rl, lat);
            n_tests++;
            if (c !== lat || bus.hi !== rh || bus.lo !== rl) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got busy=%0d %h_%h required %0d %h_%h", i, c, bus.hi, bus.lo, lat, rh, rl);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0;
        bus.flush = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wd = '0;
        #2;
        test_reset();
        test_multu_max();
        test_divu();
        test_div_by_zero();
        test_flush();
        test_reset_mid_op_and_mt();
        test_signed_ops();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit beside the ALU in the EX stage; executes MULTU/DIVU (and MULT/DIV when enabled) into architectural HI/LO registers.
- Radix-2 algorithms: shift-add multiply, restoring divide; one bit per clock.
- Drives `busy` to the hazard logic so MFHI/MFLO/MTHI/MTLO and further mul/div stall while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- start  in  1  issue pulse; sampled only in IDLE.
- op  in  2  00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
- src_a  in  WIDTH  multiplicand / dividend.
- src_b  in  WIDTH  multiplier / divisor.
- flush  in  1  abort current operation (pipeline flush).
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wd  in  WIDTH  MTHI/MTLO write data.
- busy  out  1  operation in flight.
- div_by_zero  out  1  one-cycle pulse on a divide issued with src_b == 0.
- hi  out  WIDTH  HI register (product high / remainder).
- lo  out  WIDTH  LO register (product low / quotient).

Behaviour:
- Reset (reset == 0, any time, including mid-operation): state IDLE, count 0, busy 0, div_by_zero 0, hi 0, lo 0, working registers 0.
- State machine: IDLE -> RUN -> (FIXUP, optional) -> IDLE.
- IDLE + start, normal case:
  - Latch operands, clear count, enter RUN.
  - busy rises at that edge.
- IDLE + start + divide op + src_b == 0:
  - No RUN; state stays IDLE.
  - div_by_zero = 1 for exactly one cycle.
  - hi/lo unchanged.
- RUN: one iteration per cycle; count increments 0..WIDTH-1.
  - Multiply: accumulator is 2*WIDTH bits. If the multiplier LSB is 1, add the multiplicand into the upper half; then shift right 1.
  - Divide: remainder register is WIDTH+1 bits.
    - Shift {rem, quotient} left 1.
    - Trial subtract the divisor.
    - If the result is non-negative, keep it and set quotient LSB = 1; else restore.
- Completion (iteration count reaches WIDTH, unsigned build):
  - At the edge ending iteration WIDTH-1: hi/lo written and busy falls; return to IDLE.
  - busy is high for exactly WIDTH cycles.
  - hi/lo are valid in the first cycle busy == 0.
- start while busy: ignored, no queueing.
- flush: in RUN/FIXUP, return to IDLE next edge; hi/lo keep their pre-operation values; busy falls. In IDLE, flush has no effect.
- flush and start in the same IDLE cycle: flush wins, start dropped.
- hi_we/lo_we:
  - In IDLE: write wd at the edge.
  - While busy: ignored.
  - With start in the same cycle: start wins, write dropped.
- Completion and flush in the same cycle: flush wins, no hi/lo update.
- Arithmetic is modulo 2^WIDTH; no overflow flag.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- With the macro:
  - op[1] = 1 selects signed operation.
  - At start, operands are replaced by their magnitudes and the sign bits are saved.
  - After RUN, one FIXUP cycle applies signs:
    - Product negated if the signs differ.
    - Quotient negated if the signs differ.
    - Remainder takes the dividend's sign.
  - hi/lo written at the end of FIXUP; busy lasts WIDTH+1 cycles for signed ops, WIDTH for unsigned.
- Without the macro:
  - op[1] ignored; all ops unsigned.
  - No FIXUP state; no sign registers.

Decomposition:
- Package muldiv_pkg:
  - op encoding enum (OP_MULTU, OP_DIVU, OP_MULT, OP_DIV).
  - State enum (IDLE, RUN, FIXUP).
  - Counter width constant $clog2(WIDTH+1).
- Sub-module muldiv_step: combinational single-iteration datapath (add/shift for multiply, trial-subtract/shift for divide), parameterised by WIDTH.
- FSM, counters and HI/LO registers remain in muldiv_unit.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy high 32 cycles; hi = 0xFFFFFFFE, lo = 0x00000001.
- DIVU 100 / 7 -> busy 32 cycles; lo = 14, hi = 2.
- DIVU 5 / 0, hi = lo = 0x1234 beforehand -> div_by_zero single pulse; busy never rises; hi/lo still 0x1234.
- MULTU 3 x 4 with flush on 10th busy cycle -> busy falls next edge; hi/lo keep prior values; start at same cycle as a later completion stays ignored.
- Reset mid-operation: reset = 0 on busy cycle 5 -> immediate busy = 0, hi = lo = 0. Then hi_we with wd = 0xA5A5A5A5 in IDLE -> hi = 0xA5A5A5A5. hi_we while busy -> no change.
- MULDIV_SIGNED_EN:
  - MULT -3 x 5 -> busy 33 cycles; hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
  - DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
